// File: rtl/cpu_debug_jtag_pkg.sv
// Shared definitions for the CPU debug virtual-JTAG host: scan FSM states,
// default register widths and the slave's instruction opcodes.
// Latency: n/a (types and constants only). Backpressure: n/a.
package cpu_debug_jtag_pkg;

    localparam int JTAG_DR_WIDTH = 38;
    localparam int JTAG_IR_WIDTH = 2;

    // Instruction opcodes understood by the CPU debug slave
    localparam logic [JTAG_IR_WIDTH-1:0] IR_OCIMEM_A = 2'b00;
    localparam logic [JTAG_IR_WIDTH-1:0] IR_OCIMEM_B = 2'b01;
    localparam logic [JTAG_IR_WIDTH-1:0] IR_BREAK    = 2'b10;
    localparam logic [JTAG_IR_WIDTH-1:0] IR_TRACE    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_UDR  = 3'd4,
        ST_RTI  = 3'd5,
        ST_RSP  = 3'd6
    } jtag_state_t;

endpackage

// File: rtl/cpu_debug_jtag_host_tck_gen.sv
// Scan clock generator: divides clk down to tck and flags the clk cycle in
// which tck rises or falls. Latency: tck toggles every TCK_DIV clk cycles.
// Backpressure: none; disabling holds tck low and clears the divider.
// Ports: clk/reset; clear restarts the divider, enable runs it;
//        tck is the scan clock, rise/fall pulse in the cycle whose edge
//        moves tck 0->1 / 1->0.
module cpu_debug_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tck,
    output logic rise,
    output logic fall
);

    localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic             terminal;
    logic             run;

    assign run      = enable && !clear;
    assign terminal = (div_cnt == DIV_W'(TCK_DIV - 1));

    // Events describe what the coming clk edge does to tck, so the host can
    // act on the very edge that moves tck.
    assign rise = run && terminal && !tck;
    assign fall = run && terminal && tck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            tck     <= 1'b0;
        end else if (terminal) begin
            div_cnt <= '0;
            tck     <= ~tck;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/cpu_debug_jtag_host.sv
// Host initiator for the CPU debug slave's virtual-JTAG port: one command
// (IR + DR word) becomes a full UIR/CDR/SDR/UDR/RTI scan, the tdo word is returned.
// Latency: (3+DR_WIDTH+RTI_CYCLES)*2*TCK_DIV clk edges from accept to rsp_valid.
// Backpressure: one command in flight; cmd_ready low until the response is taken,
// and the block parks in RSP with tck low while rsp_ready is low.
// Ports: cmd_* command in, rsp_* result out, tck/tdi/tdo/ir_in/ir_out and
//        vs_*/jtag_state_rti form the virtual-JTAG interface to the slave.
module cpu_debug_jtag_host
    import cpu_debug_jtag_pkg::*;
#(
    parameter int DR_WIDTH   = JTAG_DR_WIDTH,
    parameter int IR_WIDTH   = JTAG_IR_WIDTH,
    parameter int TCK_DIV    = 2,
    parameter int RTI_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [IR_WIDTH-1:0] cmd_ir,
    input  logic [DR_WIDTH-1:0] cmd_data,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DR_WIDTH-1:0] rsp_data,
    output logic [IR_WIDTH-1:0] rsp_ir_out,
    output logic                tck,
    output logic                tdi,
    input  logic                tdo,
    output logic [IR_WIDTH-1:0] ir_in,
    input  logic [IR_WIDTH-1:0] ir_out,
    output logic                vs_uir,
    output logic                vs_cdr,
    output logic                vs_sdr,
    output logic                vs_udr,
    output logic                jtag_state_rti
);

    localparam int CNT_MAX = (DR_WIDTH > RTI_CYCLES) ? DR_WIDTH : RTI_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    jtag_state_t         state;
    jtag_state_t         next_state;
    logic [DR_WIDTH-1:0] shift;
    logic [CNT_W-1:0]    period_cnt;
    logic                accept;
    logic                scanning;
    logic                rise;
    logic                fall;

    assign accept   = cmd_valid && (state == ST_IDLE);
    assign scanning = (state == ST_UIR) || (state == ST_CDR) || (state == ST_SDR) ||
                      (state == ST_UDR) || (state == ST_RTI);

    cpu_debug_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (scanning),
        .tck    (tck),
        .rise   (rise),
        .fall   (fall)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: scan states only move on a tck fall, so each one
    // occupies whole tck periods.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (cmd_valid) next_state = ST_UIR;
            ST_UIR:  if (fall) next_state = ST_CDR;
            ST_CDR:  if (fall) next_state = ST_SDR;
            ST_SDR:  if (fall && (period_cnt == CNT_W'(DR_WIDTH - 1))) next_state = ST_UDR;
            ST_UDR:  if (fall) next_state = ST_RTI;
            ST_RTI:  if (fall && (period_cnt == CNT_W'(RTI_CYCLES - 1))) next_state = ST_RSP;
            ST_RSP:  if (rsp_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state register; they therefore only change on
    // the edge that drops tck (or on accept / response handshake).
    always_comb begin
        cmd_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        vs_uir         = 1'b0;
        vs_cdr         = 1'b0;
        vs_sdr         = 1'b0;
        vs_udr         = 1'b0;
        jtag_state_rti = 1'b0;
        case (state)
            ST_IDLE: cmd_ready = 1'b1;
            ST_UIR:  vs_uir = 1'b1;
            ST_CDR:  vs_cdr = 1'b1;
            ST_SDR:  vs_sdr = 1'b1;
            ST_UDR:  vs_udr = 1'b1;
            ST_RTI:  jtag_state_rti = 1'b1;
            ST_RSP: begin
                rsp_valid = 1'b1;
                rsp_data  = shift;
            end
            default: cmd_ready = 1'b0;
        endcase
    end

    // Scan datapath. tdo/ir_out are sampled on the edge that raises tck, tdi
    // is updated on the edge that drops it, so tdi is stable across each rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift      <= '0;
            ir_in      <= '0;
            rsp_ir_out <= '0;
            tdi        <= 1'b0;
            period_cnt <= '0;
        end else begin
            if (accept) begin
                ir_in      <= cmd_ir;
                shift      <= cmd_data;
                period_cnt <= '0;
                tdi        <= 1'b0;
            end
            if (rise) begin
                if (state == ST_UIR) begin
                    rsp_ir_out <= ir_out;
                end
                if (state == ST_SDR) begin
                    shift <= {tdo, shift[DR_WIDTH-1:1]};
                end
            end
            if (fall) begin
                // Period counter restarts on every state change and otherwise
                // counts completed tck periods (SDR bit index, RTI periods).
                if (next_state != state) begin
                    period_cnt <= '0;
                end else begin
                    period_cnt <= period_cnt + 1'b1;
                end
                // shift[0] already holds the next bit after the preceding rise.
                tdi <= (next_state == ST_SDR) ? shift[0] : 1'b0;
            end
        end
    end

endmodule
